// File: rtl/div3_remainder.sv
// div3_remainder: pairs divider quotients with their operands through a FIFO and checks the remainder (optional error counter under DIV3_REM_ERR_COUNT_EN)
module div3_remainder #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH-1:0]          i_n,
  input  logic                       i_n_valid,
  input  logic [DWIDTH-1:0]          i_div3,
  input  logic                       i_div3_valid,
  output logic [DWIDTH-1:0]          o_n,
  output logic [DWIDTH-1:0]          o_quot,
  output logic [1:0]                 o_rem,
  output logic                       o_err,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic                       o_underflow,
  output logic [31:0]                o_err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DWIDTH-1:0] n_q, n_d, quot_q, quot_d, head;
  logic [DWIDTH+2:0] diff;
  logic [1:0]        rem_q, rem_d;
  logic              err_q, err_d, valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_en, wr_en, bad;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle; an empty one never bypasses.
  always_comb begin
    rd_en    = i_div3_valid && (level_q != '0);
    wr_en    = i_n_valid && ((level_q != FULL) || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(wr_en) - LW'(rd_en);
    head     = mem_q[rd_ptr_q];
    diff     = {3'b0, head} - {2'b0, i_div3, 1'b0} - {3'b0, i_div3};
    bad      = diff[DWIDTH+2] | (diff > (DWIDTH+3)'(2));
    valid_d  = rd_en;
    n_d      = rd_en ? head : n_q;
    quot_d   = rd_en ? i_div3 : quot_q;
    rem_d    = rd_en ? diff[1:0] : rem_q;
    err_d    = rd_en ? bad : err_q;
    ovf_d    = ovf_q | (i_n_valid & ~wr_en);
    udf_d    = udf_q | (i_div3_valid & ~rd_en);
  end
  // Operand storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_n;
  end
  // Pointers, occupancy, paired outputs and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      n_q      <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      n_q      <= n_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
`ifdef DIV3_REM_ERR_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  // Saturating count of mismatched pairs, visible alongside the matching o_valid.
  always_comb begin
    cnt_d = (rd_en && bad && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
  end
  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign o_err_count = cnt_q;
`else
  assign o_err_count = '0;
`endif
  assign o_n         = n_q;
  assign o_quot      = quot_q;
  assign o_rem       = rem_q;
  assign o_err       = err_q;
  assign o_valid     = valid_q;
  assign o_level     = level_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;
endmodule
